// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush-over-load priority
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [31:0]        pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [31:0]        id_pc_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic               id_valid_o
);
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    always_comb begin
        pc_d    = flush_i ? 32'd0 : load_i ? pc_i : pc_q;
        instr_d = flush_i ? NOP_INSTR : load_i ? instr_i : instr_q;
        valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 32'd0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign id_pc_o    = pc_q;
    assign id_instr_o = instr_q;
    assign id_valid_o = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, imem req/ack sequencing, skid buffer and IF/ID loading
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        nextaddr,
    input  logic               branch,
    input  logic               stall,
    output logic [31:0]        addr1,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [31:0]        id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_valid
);
    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d, req_addr_q, req_addr_d, skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d, ld_instr;
    logic [31:0]        ld_pc;
    logic               load, flush;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        load         = 1'b0;
        flush        = branch;
        ld_pc        = req_addr_q;
        ld_instr     = imem_rdata;
        if (branch) begin
            pc_d         = nextaddr;
            skid_pc_d    = 32'd0;
            skid_instr_d = NOP_INSTR;
        end
        case (state_q)
            FETCH: begin
                if (branch) begin
                    req_addr_d = imem_ack ? nextaddr : req_addr_q;
                    state_d    = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack && !stall) begin
                    load       = 1'b1;
                    pc_d       = nextaddr;
                    req_addr_d = nextaddr;
                end else if (imem_ack) begin
                    skid_pc_d    = req_addr_q;
                    skid_instr_d = imem_rdata;
                    pc_d         = nextaddr;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (branch) begin
                    req_addr_d = nextaddr;
                    state_d    = FETCH;
                end else if (!stall) begin
                    load       = 1'b1;
                    ld_pc      = skid_pc_q;
                    ld_instr   = skid_instr_q;
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                // the refetch follows any redirect that landed while draining
                if (imem_ack) begin
                    req_addr_d = pc_d;
                    state_d    = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign addr1     = pc_q + PC_INC;
    assign imem_req  = state_q != HOLD;
    assign imem_addr = req_addr_q;

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .flush_i   (flush),
        .pc_i      (ld_pc),
        .instr_i   (ld_instr),
        .id_pc_o   (id_pc),
        .id_instr_o(id_instr),
        .id_valid_o(id_valid)
    );
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly downstream of the next-PC branch mux.
- Holds the PC and produces PC+4 (addr1) for the mux. Consumes the mux's nextaddr.
- Drives a req/ack instruction-memory interface and loads the IF/ID pipeline register.
- Handles hazard stalls, branch redirect/flush, and multi-cycle memory waits.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on reset/flush

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
nextaddr  input  32  next PC from branch mux (jaddr when branch, else addr1)
branch  input  1  taken-branch/jump indicator (same signal as mux select); redirect + flush
stall  input  1  hazard-unit stall; IF/ID and PC hold
addr1  output  32  pc + 4, fed to branch mux
imem_req  output  1  instruction-memory request
imem_addr  output  32  fetch address, stable while imem_req=1 and imem_ack=0
imem_ack  input  1  memory returns imem_rdata this cycle (same-cycle ack allowed)
imem_rdata  input  32  instruction word
id_pc  output  32  PC of instruction in IF/ID
id_instr  output  32  instruction in IF/ID
id_valid  output  1  IF/ID holds a live instruction

Behaviour:
- Reset (async, rst_n=0), all outputs registered except addr1, imem_req and imem_addr:
  - pc=RESET_PC; req_addr=RESET_PC; state=FETCH.
  - id_pc=0; id_instr=NOP_INSTR; id_valid=0; skid buffer empty.
- Reset mid-transaction abandons the in-flight request. Memory must tolerate a dropped req.
- addr1 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). No alignment check.
- imem_req=1 in FETCH and DRAIN, 0 in HOLD. imem_addr = req_addr.
- req_addr loads pc whenever entering or staying in FETCH with a new pc.
- States:
  - FETCH, waiting for ack:
    - ack=0, branch=0: hold all registers.
    - ack=1, branch=0, stall=0: IF/ID <= {req_addr, rdata, valid=1}; pc <= nextaddr; req_addr <= nextaddr. Stay in FETCH.
      - Zero-wait memory gives 1 instr/cycle.
    - ack=1, branch=0, stall=1: skid <= {req_addr, rdata}; pc <= nextaddr; go HOLD.
    - branch=1 takes priority over stall and ack:
      - pc <= nextaddr; IF/ID <= {0, NOP_INSTR, 0}; skid cleared.
      - ack=1 this cycle: rdata discarded; req_addr <= nextaddr; stay FETCH.
      - ack=0 this cycle: go DRAIN, req_addr unchanged.
  - HOLD, skid full, no request issued:
    - stall=1, branch=0: hold.
    - stall=0, branch=0: IF/ID <= skid, valid=1; req_addr <= pc; go FETCH.
    - branch=1: flush as above; skid dropped; req_addr <= nextaddr; go FETCH.
  - DRAIN, old request outstanding, result unwanted:
    - Keep req/addr stable. IF/ID stays flushed.
    - On ack: discard data; req_addr <= pc; go FETCH.
    - A further branch in DRAIN updates pc only.
- While stall=1 and no branch: IF/ID never changes. id_valid never asserts for a squashed fetch.
- pc advances only when an instruction is accepted or a branch redirects.
- branch=0 implies nextaddr==addr1; the block does not check this.

Decomposition:
- Shared package cpu_pkg:
  - state encoding FETCH/HOLD/DRAIN (2-bit).
  - localparams INSTR_W=32, PC_INC=4.
  - NOP_INSTR default.
- Natural sub-module: if_id_reg (IF/ID pipeline register with load/flush/hold controls, async active-low reset).
- FSM, PC, req_addr and skid buffer stay in the top module.

Test Plan:
1. Reset release, imem_ack tied 1, rdata=pc-derived: imem_addr 0x0,0x4,0x8 on consecutive cycles; id_pc 0x0 one cycle after first ack; id_valid=1 from that cycle; addr1=0x4 at reset.
2. 2-wait-state memory: imem_addr=0x0 held 3 cycles; id_valid low until ack; pc becomes 0x4 only after ack.
3. stall=1 for 3 cycles coinciding with ack at 0x8: state HOLD, imem_req=0, id_pc unchanged; stall drop -> id_pc=0x8, next imem_addr=0xC.
4. branch=1, nextaddr=0x100 while waiting on 0x10: id_valid=0 next cycle, imem_addr stays 0x10 until ack, data dropped, next imem_addr=0x100, id_pc=0x100 after its ack.
5. branch=1 and stall=1 simultaneously, nextaddr=0x200, state HOLD: skid dropped, id_valid=0, imem_addr=0x200 next cycle.
6. pc=0xFFFF_FFFC: addr1=0x0 and next fetch at 0x0; separately, rst_n low mid-wait -> all outputs at reset values immediately, imem_addr=RESET_PC.
